// File: rtl/rvfi_mem_arbiter_if.sv
// Native memory-port bundle (valid/ready, instr, addr, wdata, wstrb, rdata).
// A requester uses the master modport; the responder uses the slave modport.
interface rvfi_mem_arbiter_if;
   logic        valid;
   logic        instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   modport master (output valid, instr, addr, wdata, wstrb, input  ready, rdata);
   modport slave  (input  valid, instr, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/rvfi_mem_arbiter.sv
// Two-master round-robin arbiter onto one native memory port, with one outstanding
// access and a bounded-wait timeout that force-completes a hung slave.
module rvfi_mem_arbiter #(
   parameter int          TIMEOUT       = 16,
   parameter logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF
) (
   input  logic                    clk,
   input  logic                    resetn,
   rvfi_mem_arbiter_if.slave       m0,
   rvfi_mem_arbiter_if.slave       m1,
   rvfi_mem_arbiter_if.master      s,
   output logic                    grant,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [7:0]              timeout_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY0 = 2'd1;
   localparam logic [1:0] ST_BUSY1 = 2'd2;

   logic [1:0]  r_state;
   logic        r_last;
   logic        r_grant;
   logic [31:0] r_wcnt;
   logic [7:0]  r_timeout_cnt;

   logic        w_in_busy;
   logic        w_sel;
   logic        w_sel_valid;
   logic        w_to_hit;
   logic        w_done;
   logic        w_to_err;
   logic [31:0] w_rdata;
   logic [1:0]  w_m_ready;
   logic [31:0] w_m_rdata [2];

   assign w_in_busy   = (r_state == ST_BUSY0) || (r_state == ST_BUSY1);
   assign w_sel       = (r_state == ST_BUSY1);
   assign w_sel_valid = w_in_busy && (w_sel ? m1.valid : m0.valid);

   generate
      if (TIMEOUT == 0) begin : g_no_timeout
         assign w_to_hit = 1'b0;
      end else begin : g_timeout
         localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT - 1);
         assign w_to_hit = (r_wcnt == TO_LIMIT);
      end
   endgenerate

   // A master that dropped valid mid-access gets no completion and no error.
   assign w_done   = w_sel_valid && (s.ready || w_to_hit);
   assign w_to_err = w_sel_valid && !s.ready && w_to_hit;
   assign w_rdata  = s.ready ? s.rdata : TIMEOUT_RDATA;

   assign s.valid = w_sel_valid;
   assign s.instr = w_sel_valid && (w_sel ? m1.instr : m0.instr);
   assign s.addr  = w_sel_valid ? (w_sel ? m1.addr  : m0.addr)  : 32'd0;
   assign s.wdata = w_sel_valid ? (w_sel ? m1.wdata : m0.wdata) : 32'd0;
   assign s.wstrb = w_sel_valid ? (w_sel ? m1.wstrb : m0.wstrb) : 4'd0;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_resp
         assign w_m_ready[gi] = w_done && (w_sel == 1'(gi));
         assign w_m_rdata[gi] = w_m_ready[gi] ? w_rdata : 32'd0;
      end
   endgenerate

   assign m0.ready    = w_m_ready[0];
   assign m0.rdata    = w_m_rdata[0];
   assign m1.ready    = w_m_ready[1];
   assign m1.rdata    = w_m_rdata[1];
   assign grant       = r_grant;
   assign busy        = w_in_busy;
   assign timeout_err = w_to_err;
   assign timeout_cnt = r_timeout_cnt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_last        <= 1'b1;
         r_grant       <= 1'b0;
         r_wcnt        <= 32'd0;
         r_timeout_cnt <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_wcnt <= 32'd0;
               // On a tie the master not serviced last wins.
               if (m0.valid && (!m1.valid || r_last)) begin
                  r_state <= ST_BUSY0;
                  r_grant <= 1'b0;
               end else if (m1.valid) begin
                  r_state <= ST_BUSY1;
                  r_grant <= 1'b1;
               end
            end
            ST_BUSY0, ST_BUSY1: begin
               if (!w_sel_valid) begin
                  r_state <= ST_IDLE;
                  r_wcnt  <= 32'd0;
               end else if (w_done) begin
                  r_state <= ST_IDLE;
                  r_last  <= w_sel;
                  r_wcnt  <= 32'd0;
                  if (w_to_err && (r_timeout_cnt != 8'hFF))
                     r_timeout_cnt <= r_timeout_cnt + 8'd1;
               end else begin
                  r_wcnt <= r_wcnt + 32'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_wcnt  <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rvfi_mem_arbiter.sv
// Directed self-checking bench for rvfi_mem_arbiter: inputs change on the falling
// edge, outputs are sampled 1 time unit later.
module tb_rvfi_mem_arbiter;

   logic       clk;
   logic       resetn;
   logic       grant;
   logic       busy;
   logic       timeout_err;
   logic [7:0] timeout_cnt;
   int         errors;
   int         checks;

   rvfi_mem_arbiter_if m0_if ();
   rvfi_mem_arbiter_if m1_if ();
   rvfi_mem_arbiter_if s_if ();

   rvfi_mem_arbiter #(.TIMEOUT(16), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .m0          (m0_if),
      .m1          (m1_if),
      .s           (s_if),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeout_err),
      .timeout_cnt (timeout_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      m0_if.valid = 1'b0; m0_if.instr = 1'b0; m0_if.addr = 32'd0; m0_if.wdata = 32'd0; m0_if.wstrb = 4'd0;
      m1_if.valid = 1'b0; m1_if.instr = 1'b0; m1_if.addr = 32'd0; m1_if.wdata = 32'd0; m1_if.wstrb = 4'd0;
      s_if.ready  = 1'b0; s_if.rdata  = 32'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      resetn = 1'b0;
      m0_if.valid = 1'b1;
      m1_if.valid = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (s_if.valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid: got %b want 0", s_if.valid); end
      checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant); end
      checks++; if (timeout_cnt !== 8'd0) begin errors++; $display("FAIL reset_timeout_cnt: got %0d want 0", timeout_cnt); end
      checks++; if ({m0_if.ready, m1_if.ready, timeout_err} !== 3'b000) begin errors++;
         $display("FAIL reset_ready: got %b want 000", {m0_if.ready, m1_if.ready, timeout_err}); end
      checks++; if (s_if.addr !== 32'd0) begin errors++; $display("FAIL reset_s_addr: got %h want 0", s_if.addr); end
      @(negedge clk);
      idle_inputs();
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_read();
      m0_if.valid = 1'b1; m0_if.addr = 32'h100; m0_if.wstrb = 4'd0; m0_if.instr = 1'b1;
      #1;
      checks++; if (s_if.valid !== 1'b0) begin errors++; $display("FAIL rd_s_valid_early: got %b want 0", s_if.valid); end
      @(negedge clk); #1;
      checks++; if ({s_if.valid, s_if.instr, busy, grant} !== 4'b1110) begin errors++;
         $display("FAIL rd_busy_state: got %b want 1110", {s_if.valid, s_if.instr, busy, grant}); end
      checks++; if (s_if.addr !== 32'h100) begin errors++; $display("FAIL rd_s_addr: got %h want 00000100", s_if.addr); end
      checks++; if (m0_if.ready !== 1'b0) begin errors++; $display("FAIL rd_ready_early: got %b want 0", m0_if.ready); end
      @(negedge clk);
      s_if.ready = 1'b1; s_if.rdata = 32'h12345678;
      #1;
      checks++; if (m0_if.ready !== 1'b1) begin errors++; $display("FAIL rd_m0_ready: got %b want 1", m0_if.ready); end
      checks++; if (m0_if.rdata !== 32'h12345678) begin errors++; $display("FAIL rd_m0_rdata: got %h want 12345678", m0_if.rdata); end
      checks++; if (m1_if.ready !== 1'b0) begin errors++; $display("FAIL rd_m1_ready: got %b want 0", m1_if.ready); end
      $display("txn m0 read addr=%h rdata=%h", m0_if.addr, m0_if.rdata);
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if ({busy, m0_if.ready} !== 2'b00 || m0_if.rdata !== 32'd0) begin errors++;
         $display("FAIL rd_after: got busy/ready %b rdata %h want 00/0", {busy, m0_if.ready}, m0_if.rdata); end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic exp_g;
      resetn = 1'b0;
      m0_if.valid = 1'b1; m0_if.addr = 32'h1000;
      m1_if.valid = 1'b1; m1_if.addr = 32'h2000;
      s_if.ready = 1'b1; s_if.rdata = 32'h0BADF00D;
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_g = 1'(i % 2);
         @(negedge clk); #1;
         checks++; if ({busy, grant, m0_if.ready, m1_if.ready} !== {1'b1, exp_g, !exp_g, exp_g}) begin errors++;
            $display("FAIL rr_txn%0d: got busy/grant/r0/r1 %b want %b", i,
                     {busy, grant, m0_if.ready, m1_if.ready}, {1'b1, exp_g, !exp_g, exp_g}); end
         checks++; if (s_if.addr !== (exp_g ? 32'h2000 : 32'h1000)) begin errors++;
            $display("FAIL rr_addr%0d: got %h want %h", i, s_if.addr, exp_g ? 32'h2000 : 32'h1000); end
         $display("txn rr%0d grant=m%0d addr=%h", i, grant, s_if.addr);
         @(negedge clk); #1;
         checks++; if ({busy, s_if.valid, m0_if.ready, m1_if.ready} !== 4'b0000) begin errors++;
            $display("FAIL rr_gap%0d: got %b want 0000", i, {busy, s_if.valid, m0_if.ready, m1_if.ready}); end
      end
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_m1_write();
      m1_if.valid = 1'b1; m1_if.addr = 32'h40; m1_if.wdata = 32'hCAFEF00D; m1_if.wstrb = 4'b0011;
      m0_if.addr = 32'h5555_0000; m0_if.wdata = 32'h1111_2222;
      @(negedge clk); #1;
      checks++; if ({s_if.valid, grant, m1_if.ready} !== 3'b110) begin errors++;
         $display("FAIL wr_state: got %b want 110", {s_if.valid, grant, m1_if.ready}); end
      checks++; if (s_if.addr !== 32'h40 || s_if.wdata !== 32'hCAFEF00D || s_if.wstrb !== 4'b0011) begin errors++;
         $display("FAIL wr_fields: got %h/%h/%b want 00000040/cafef00d/0011", s_if.addr, s_if.wdata, s_if.wstrb); end
      @(negedge clk);
      s_if.ready = 1'b1;
      #1;
      checks++; if ({m1_if.ready, m0_if.ready} !== 2'b10) begin errors++;
         $display("FAIL wr_ready: got r1/r0 %b want 10", {m1_if.ready, m0_if.ready}); end
      $display("txn m1 write addr=%h wdata=%h wstrb=%b", s_if.addr, s_if.wdata, s_if.wstrb);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int early;
      m0_if.valid = 1'b1; m0_if.addr = 32'h200;
      early = 0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk); #1;
         if (m0_if.ready || timeout_err) early++;
      end
      checks++; if (early !== 0) begin errors++; $display("FAIL to_early: got %0d early completions want 0", early); end
      @(negedge clk); #1;
      checks++; if ({m0_if.ready, timeout_err} !== 2'b11) begin errors++;
         $display("FAIL to_ready_err: got %b want 11", {m0_if.ready, timeout_err}); end
      checks++; if (m0_if.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_rdata: got %h want deadbeef", m0_if.rdata); end
      checks++; if (timeout_cnt !== 8'd0) begin errors++; $display("FAIL to_cnt_before: got %0d want 0", timeout_cnt); end
      $display("txn m0 timeout addr=%h rdata=%h", m0_if.addr, m0_if.rdata);
      @(negedge clk);
      m0_if.valid = 1'b0;
      #1;
      checks++; if ({busy, timeout_err} !== 2'b00 || timeout_cnt !== 8'd1) begin errors++;
         $display("FAIL to_cnt_after: got busy/err %b cnt %0d want 00 cnt 1", {busy, timeout_err}, timeout_cnt); end
      @(negedge clk);
      // s_ready arriving on the limit cycle wins over the timeout.
      m0_if.valid = 1'b1;
      repeat (16) @(negedge clk);
      s_if.ready = 1'b1; s_if.rdata = 32'h55AA55AA;
      #1;
      checks++; if ({m0_if.ready, timeout_err} !== 2'b10 || m0_if.rdata !== 32'h55AA55AA) begin errors++;
         $display("FAIL to_race: got ready/err %b rdata %h want 10 55aa55aa", {m0_if.ready, timeout_err}, m0_if.rdata); end
      $display("txn m0 read at limit rdata=%h", m0_if.rdata);
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (timeout_cnt !== 8'd1) begin errors++; $display("FAIL to_race_cnt: got %0d want 1", timeout_cnt); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      m1_if.valid = 1'b1; m1_if.addr = 32'h300;
      m0_if.addr = 32'h400;
      @(negedge clk); @(negedge clk); #1;
      checks++; if ({busy, grant} !== 2'b11) begin errors++; $display("FAIL rm_busy1: got %b want 11", {busy, grant}); end
      resetn = 1'b0;
      @(negedge clk); #1;
      checks++; if ({busy, s_if.valid, m1_if.ready, grant} !== 4'b0000 || timeout_cnt !== 8'd0) begin errors++;
         $display("FAIL rm_after_reset: got %b cnt %0d want 0000 cnt 0", {busy, s_if.valid, m1_if.ready, grant}, timeout_cnt); end
      resetn = 1'b1;
      m0_if.valid = 1'b1;
      @(negedge clk); #1;
      checks++; if ({busy, grant} !== 2'b10 || s_if.addr !== 32'h400) begin errors++;
         $display("FAIL rm_first_grant: got busy/grant %b addr %h want 10 00000400", {busy, grant}, s_if.addr); end
      $display("txn reset mid-access, next grant=m%0d", grant);
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_saturation();
      int pulses;
      pulses = 0;
      m0_if.valid = 1'b1;
      for (int c = 0; c < 300 * 17 + 50 && pulses < 300; c++) begin
         @(negedge clk); #1;
         if (timeout_err) begin
            pulses++;
            if (pulses == 100) begin
               checks++; if (timeout_cnt !== 8'd99) begin errors++; $display("FAIL sat_mid: got %0d want 99", timeout_cnt); end
            end
         end
      end
      checks++; if (pulses !== 300) begin errors++; $display("FAIL sat_pulses: got %0d want 300", pulses); end
      @(negedge clk);
      m0_if.valid = 1'b0;
      #1;
      checks++; if (timeout_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d want 255", timeout_cnt); end
      $display("txn %0d consecutive timeouts, timeout_cnt=%0d", pulses, timeout_cnt);
      @(negedge clk);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      idle_inputs();
      resetn = 1'b0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_m1_write();
      test_timeout();
      test_reset_mid();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
